// File: rtl/muldiv_pkg.sv
`default_nettype none
// =============================================================================
// Module : muldiv_pkg
// Brief  : Shared state encoding and constants for the HI/LO mul/div sequencer.
// Rev    : 1.0  initial release
// =============================================================================
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_HI    = 2'b01;
    localparam logic [1:0] WB_LO    = 2'b10;
    localparam logic [1:0] WB_SHIFT = 2'b11;

    // Quotient reported on divide-by-zero; sliced down to the operand width.
    localparam logic [63:0] DIV0_QUOT = '1;

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// =============================================================================
// Module : muldiv_iter
// Brief  : One shift-add multiply or restoring-divide step per cycle.
// Rev    : 1.0  initial release
// =============================================================================
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             loadMul,
    input  logic             mulMode,
    input  logic             step,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] nextHi,
    output logic [WIDTH-1:0] nextLo
);

    logic [WIDTH-1:0] r_accHi;
    logic [WIDTH-1:0] r_accLo;
    logic [WIDTH-1:0] r_operand;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_diff;

    // Multiply: accLo holds the multiplier. Divide: accLo holds the dividend
    // shifting out on top while quotient bits shift in at the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_accHi   <= '0;
            r_accLo   <= '0;
            r_operand <= '0;
        end else if (load) begin
            r_accHi   <= '0;
            r_accLo   <= loadMul ? opB : opA;
            r_operand <= loadMul ? opA : opB;
        end else if (step) begin
            r_accHi   <= nextHi;
            r_accLo   <= nextLo;
        end
    end

    always_comb begin
        w_sum     = {1'b0, r_accHi} + (r_accLo[0] ? {1'b0, r_operand} : {(WIDTH+1){1'b0}});
        w_shifted = {r_accHi, r_accLo[WIDTH-1]};
        w_diff    = w_shifted - {1'b0, r_operand};
        if (mulMode) begin
            nextHi = w_sum[WIDTH:1];
            nextLo = {w_sum[0], r_accLo[WIDTH-1:1]};
        end else if (!w_diff[WIDTH]) begin
            nextHi = w_diff[WIDTH-1:0];
            nextLo = {r_accLo[WIDTH-2:0], 1'b1};
        end else begin
            nextHi = w_shifted[WIDTH-1:0];
            nextLo = {r_accLo[WIDTH-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// =============================================================================
// Module : hilo_muldiv_ctrl
// Brief  : EX-stage MULTU/DIVU sequencer, HI/LO owner, hazard stall and
//          writeback select. Define MULDIV_SIGNED_EN for signed MULT/DIV.
// Rev    : 1.0  initial release
// =============================================================================
module hilo_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_mul,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic             rd_hi,
    input  logic             rd_lo,
    input  logic             is_shift,
`ifdef MULDIV_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       wb_sel,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_isMul;
    logic               r_negQ;
    logic               r_negR;

    logic               w_signed;
    logic               w_accept;
    logic               w_divZero;
    logic               w_lastIter;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [WIDTH-1:0]   w_iterHi;
    logic [WIDTH-1:0]   w_iterLo;
    logic [WIDTH-1:0]   w_finalHi;
    logic [WIDTH-1:0]   w_finalLo;
    logic [2*WIDTH-1:0] w_prod;

`ifdef MULDIV_SIGNED_EN
    assign w_signed = signed_op;
`else
    assign w_signed = 1'b0;
`endif

    assign w_accept   = (r_state != ST_RUN) && (start_mul || start_div);
    assign w_divZero  = !start_mul && start_div && (op_b == '0);
    assign w_lastIter = (r_count == CNT_W'(WIDTH-1));
    assign w_magA     = (w_signed && op_a[WIDTH-1]) ? (-op_a) : op_a;
    assign w_magB     = (w_signed && op_b[WIDTH-1]) ? (-op_b) : op_b;

    muldiv_iter #(
        .WIDTH   (WIDTH)
    ) u_iter (
        .clk     (clk),
        .rst     (rst),
        .load    (w_accept && !w_divZero),
        .loadMul (start_mul),
        .mulMode (r_isMul),
        .step    (r_state == ST_RUN),
        .opA     (w_magA),
        .opB     (w_magB),
        .nextHi  (w_iterHi),
        .nextLo  (w_iterLo)
    );

    // Sign fix-up folds into the last iteration's write so latency is unchanged.
    always_comb begin
        w_prod = r_negQ ? (-{w_iterHi, w_iterLo}) : {w_iterHi, w_iterLo};
        if (r_isMul) begin
            {w_finalHi, w_finalLo} = w_prod;
        end else begin
            w_finalLo = r_negQ ? (-w_iterLo) : w_iterLo;
            w_finalHi = r_negR ? (-w_iterHi) : w_iterHi;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) w_nextState = w_divZero ? ST_DONE : ST_RUN;
                else          w_nextState = ST_IDLE;
            end
            ST_RUN:  if (w_lastIter) w_nextState = ST_DONE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_isMul <= 1'b0;
            r_negQ  <= 1'b0;
            r_negR  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (wr_hi && !stall) r_hi <= op_a;
            if (wr_lo && !stall) r_lo <= op_a;
            if (w_accept) begin
                r_isMul <= start_mul;
                r_negQ  <= w_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                r_negR  <= w_signed && op_a[WIDTH-1];
                r_count <= '0;
                if (w_divZero) begin
                    r_hi <= op_a;
                    r_lo <= DIV0_QUOT[WIDTH-1:0];
                end
            end else if (r_state == ST_RUN) begin
                r_count <= r_count + 1'b1;
                if (w_lastIter) begin
                    r_hi <= w_finalHi;
                    r_lo <= w_finalLo;
                end
            end
        end
    end

    always_comb begin
        if (rd_hi)         wb_sel = WB_HI;
        else if (rd_lo)    wb_sel = WB_LO;
        else if (is_shift) wb_sel = WB_SHIFT;
        else               wb_sel = WB_ALU;
    end

    assign busy  = (r_state == ST_RUN);
    assign done  = (r_state == ST_DONE);
    assign stall = busy && (start_mul || start_div || rd_hi || rd_lo || wr_hi || wr_lo);
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
`default_nettype none
// =============================================================================
// Module : tb_hilo_muldiv_ctrl
// Brief  : Directed self-checking bench for hilo_muldiv_ctrl.
// Rev    : 1.0  initial release
// =============================================================================
module tb_hilo_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        start_mul, start_div;
    logic [31:0] op_a, op_b;
    logic        wr_hi, wr_lo, rd_hi, rd_lo, is_shift;
`ifdef MULDIV_SIGNED_EN
    logic        signed_op;
`endif
    logic [31:0] hi, lo;
    logic [1:0]  wb_sel;
    logic        busy, done, stall;

    int checks = 0;
    int errors = 0;

    hilo_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_mul (start_mul),
        .start_div (start_div),
        .op_a      (op_a),
        .op_b      (op_b),
        .wr_hi     (wr_hi),
        .wr_lo     (wr_lo),
        .rd_hi     (rd_hi),
        .rd_lo     (rd_lo),
        .is_shift  (is_shift),
`ifdef MULDIV_SIGNED_EN
        .signed_op (signed_op),
`endif
        .hi        (hi),
        .lo        (lo),
        .wb_sel    (wb_sel),
        .busy      (busy),
        .done      (done),
        .stall     (stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clears starts after the acceptance edge and returns the cycle index
    // (start cycle = 0) at which done is seen, or 60 on timeout.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cyc < 60) begin
            tick();
            cyc++;
            start_mul = 1'b0;
            start_div = 1'b0;
            op_a = 32'h5A5A_A5A5;
            op_b = 32'hA5A5_5A5A;
            #1;
            if (done === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++;
            $display("FAIL reset_hilo hi=%h lo=%h expected 0/0", hi, lo); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin errors++;
            $display("FAIL reset_flags busy=%b done=%b stall=%b expected 000", busy, done, stall); end
        checks++; if (wb_sel !== 2'b00) begin errors++;
            $display("FAIL reset_wbsel got %b expected 00", wb_sel); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mul();
        int cyc, busyCnt;
        start_mul = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'h2;
        tick();
        start_mul = 1'b0; op_a = 32'h1111_1111; op_b = 32'h3333_3333;
        cyc = 1; busyCnt = 0;
        #1;
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++;
            $display("FAIL mul_hilo_held hi=%h lo=%h expected 0/0", hi, lo); end
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busyCnt++;
            tick(); cyc++;
        end
        checks++; if (cyc !== 33) begin errors++;
            $display("FAIL mul_done_cycle got %0d expected 33", cyc); end
        checks++; if (busyCnt !== 32) begin errors++;
            $display("FAIL mul_busy_cycles got %0d expected 32", busyCnt); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL mul_busy_at_done got %b expected 0", busy); end
        checks++; if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin errors++;
            $display("FAIL mul_result hi=%h lo=%h expected 00000001/fffffffe", hi, lo); end
        tick();
        checks++; if (done !== 1'b0) begin errors++;
            $display("FAIL mul_done_pulse got %b expected 0", done); end
    endtask

    task automatic test_div();
        int cyc;
        start_div = 1'b1; op_a = 32'd100; op_b = 32'd7;
        wait_done(cyc);
        checks++; if (cyc !== 33) begin errors++;
            $display("FAIL div_done_cycle got %0d expected 33", cyc); end
        checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++;
            $display("FAIL div_result hi=%0d lo=%0d expected 2/14", hi, lo); end
        tick();
        rd_lo = 1'b1;
        #1;
        checks++; if (wb_sel !== 2'b10 || stall !== 1'b0) begin errors++;
            $display("FAIL div_mflo wb_sel=%b stall=%b expected 10/0", wb_sel, stall); end
        rd_lo = 1'b0;
        tick();
    endtask

    task automatic test_mfhi_stall();
        int stallErr, selErr;
        start_mul = 1'b1; op_a = 32'd5; op_b = 32'd6;
        stallErr = 0; selErr = 0;
        for (int k = 1; k <= 33; k++) begin
            tick();
            start_mul = 1'b0;
            rd_hi = (k >= 5);
            wr_lo = (k >= 5 && k <= 32);
            op_a  = 32'h0000_DEAD;
            #1;
            if (stall !== ((k >= 5 && k <= 32) ? 1'b1 : 1'b0)) stallErr++;
            if (k >= 5 && wb_sel !== 2'b01) selErr++;
            if (k == 32) begin
                checks++; if (lo !== 32'd14) begin errors++;
                    $display("FAIL stall_blocks_mtlo lo=%h expected 0000000e", lo); end
            end
        end
        checks++; if (stallErr !== 0) begin errors++;
            $display("FAIL mfhi_stall_window bad_cycles=%0d expected 0", stallErr); end
        checks++; if (selErr !== 0) begin errors++;
            $display("FAIL mfhi_wbsel bad_cycles=%0d expected 0", selErr); end
        checks++; if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'd30) begin errors++;
            $display("FAIL mfhi_result done=%b hi=%h lo=%h expected 1/0/1e", done, hi, lo); end
        rd_hi = 1'b0; wr_lo = 1'b0;
        tick();
    endtask

    task automatic test_mthi_mtlo();
        wr_hi = 1'b1; op_a = 32'hCAFE_0001;
        tick();
        checks++; if (hi !== 32'hCAFE_0001) begin errors++;
            $display("FAIL mthi got %h expected cafe0001", hi); end
        wr_hi = 1'b0; wr_lo = 1'b1; op_a = 32'h0BAD_F00D;
        tick();
        wr_lo = 1'b0;
        checks++; if (lo !== 32'h0BAD_F00D || hi !== 32'hCAFE_0001) begin errors++;
            $display("FAIL mtlo hi=%h lo=%h expected cafe0001/0badf00d", hi, lo); end
    endtask

    task automatic test_wb_sel();
        rd_hi = 1'b1; rd_lo = 1'b1; is_shift = 1'b1; #1;
        checks++; if (wb_sel !== 2'b01) begin errors++;
            $display("FAIL wbsel_hi got %b expected 01", wb_sel); end
        rd_hi = 1'b0; #1;
        checks++; if (wb_sel !== 2'b10) begin errors++;
            $display("FAIL wbsel_lo got %b expected 10", wb_sel); end
        rd_lo = 1'b0; #1;
        checks++; if (wb_sel !== 2'b11) begin errors++;
            $display("FAIL wbsel_shift got %b expected 11", wb_sel); end
        is_shift = 1'b0; #1;
        checks++; if (wb_sel !== 2'b00) begin errors++;
            $display("FAIL wbsel_alu got %b expected 00", wb_sel); end
        tick();
    endtask

    task automatic test_priority();
        int cyc;
        start_mul = 1'b1; start_div = 1'b1; op_a = 32'd6; op_b = 32'd3;
        wait_done(cyc);
        checks++; if (cyc !== 33 || lo !== 32'd18 || hi !== 32'd0) begin errors++;
            $display("FAIL priority cyc=%0d hi=%0d lo=%0d expected 33/0/18", cyc, hi, lo); end
        tick();
    endtask

    task automatic test_div0();
        start_div = 1'b1; op_a = 32'h1234; op_b = 32'h0;
        tick();
        start_div = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++;
            $display("FAIL div0_flags busy=%b done=%b expected 0/1", busy, done); end
        checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'h1234) begin errors++;
            $display("FAIL div0_result hi=%h lo=%h expected 00001234/ffffffff", hi, lo); end
        tick();
        checks++; if (done !== 1'b0) begin errors++;
            $display("FAIL div0_done_pulse got %b expected 0", done); end
    endtask

    task automatic test_reset_mid();
        int cyc, doneSeen;
        start_div = 1'b1; op_a = 32'd1000; op_b = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            tick();
            start_div = 1'b0;
        end
        rst = 1'b1;
        #1;
        checks++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin errors++;
            $display("FAIL rst_mid hi=%h lo=%h busy=%b done=%b expected 0/0/0/0", hi, lo, busy, done); end
        tick(); tick();
        rst = 1'b0;
        doneSeen = 0;
        for (int k = 0; k < 35; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) doneSeen++;
        end
        checks++; if (doneSeen !== 0) begin errors++;
            $display("FAIL rst_mid_quiet active_cycles=%0d expected 0", doneSeen); end
        start_mul = 1'b1; op_a = 32'd3; op_b = 32'd4;
        wait_done(cyc);
        checks++; if (cyc !== 33 || lo !== 32'd12 || hi !== 32'd0) begin errors++;
            $display("FAIL rst_mid_mul cyc=%0d hi=%0d lo=%0d expected 33/0/12", cyc, hi, lo); end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_mul = 1'b1; op_a = 32'd7; op_b = 32'd9;
        wait_done(cyc);
        checks++; if (cyc !== 33 || lo !== 32'd63) begin errors++;
            $display("FAIL b2b_first cyc=%0d lo=%0d expected 33/63", cyc, lo); end
        start_mul = 1'b1; op_a = 32'h0001_0000; op_b = 32'h0001_0000;
        #1;
        checks++; if (stall !== 1'b0) begin errors++;
            $display("FAIL b2b_stall got %b expected 0", stall); end
        wait_done(cyc);
        checks++; if (cyc !== 33 || hi !== 32'h1 || lo !== 32'h0) begin errors++;
            $display("FAIL b2b_second cyc=%0d hi=%h lo=%h expected 33/1/0", cyc, hi, lo); end
        tick();
    endtask

`ifdef MULDIV_SIGNED_EN
    task automatic test_signed();
        int cyc;
        signed_op = 1'b1;
        start_mul = 1'b1; op_a = 32'hFFFF_FFFD; op_b = 32'd5;
        wait_done(cyc);
        checks++; if (cyc !== 33 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin errors++;
            $display("FAIL signed_mul cyc=%0d hi=%h lo=%h expected 33/ffffffff/fffffff1", cyc, hi, lo); end
        tick();
        signed_op = 1'b1;
        start_div = 1'b1; op_a = 32'hFFFF_FFF9; op_b = 32'd2;
        wait_done(cyc);
        checks++; if (cyc !== 33 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin errors++;
            $display("FAIL signed_div cyc=%0d hi=%h lo=%h expected 33/ffffffff/fffffffd", cyc, hi, lo); end
        signed_op = 1'b0;
        tick();
    endtask
`endif

    initial begin
        start_mul = 1'b0; start_div = 1'b0;
        op_a = 32'h0; op_b = 32'h0;
        wr_hi = 1'b0; wr_lo = 1'b0; rd_hi = 1'b0; rd_lo = 1'b0; is_shift = 1'b0;
`ifdef MULDIV_SIGNED_EN
        signed_op = 1'b0;
`endif
        test_reset();
        test_mul();
        test_div();
        test_mfhi_stall();
        test_mthi_mtlo();
        test_wb_sel();
        test_priority();
        test_div0();
        test_reset_mid();
        test_back_to_back();
`ifdef MULDIV_SIGNED_EN
        test_signed();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
